dcache_refill: RTL and testbench
================================

# dcache_refill

Miss/refill and write-through controller sitting directly downstream of the 2-way, 8-set data cache and upstream of the data memory. On a cache miss it fetches the 4-word (16-byte) block from memory as four single-word reads and returns the whole block to the cache for installation. Stores from the cache are forwarded to memory as single write-through transactions (word or byte). It serialises both request kinds so memory sees at most one controller activity at a time.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, word width
- BLOCK_WORDS, 4, words per cache block (fixed; power of two)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- miss_req  in  1  cache requests a block refill; held until miss_ready
- miss_addr  in  ADDR_WIDTH  any byte address within the missing block
- miss_ready  out  1  refill request accepted this cycle when miss_req & miss_ready
- wr_req  in  1  cache requests a write-through store; held until wr_ready
- wr_addr  in  ADDR_WIDTH  store byte address
- wr_data  in  DATA_WIDTH  store data (byte store uses [7:0])
- wr_byte  in  1  0 = SW, 1 = SB
- wr_ready  out  1  store accepted this cycle when wr_req & wr_ready
- wr_done  out  1  one-cycle pulse: store accepted by memory
- fill_valid  out  1  one-cycle pulse: fill_addr/fill_data valid
- fill_addr  out  ADDR_WIDTH  block base address (low 4 bits zero)
- fill_data  out  BLOCK_WORDS*DATA_WIDTH  word i at [32i+31:32i]
- busy  out  1  state != IDLE
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  transaction address
- mem_wdata  out  DATA_WIDTH  write data
- mem_st_byte  out  1  byte store select
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rdata  in  DATA_WIDTH  read data
- mem_rvalid  in  1  mem_rdata valid; responses in request order, ≥1 cycle after acceptance

## Operation
- States: IDLE, WR, RD, DONE.
- IDLE: wr_ready = 1; miss_ready = ~wr_req (store wins a simultaneous request, so refill reads see the new data).
- Store accepted -> WR: mem_req=1, mem_we=1, address/data/byte registered from request. On mem_ready -> IDLE, wr_done pulses next cycle.
- Miss accepted -> RD: base = miss_addr & ~0xF. Issue counter iss (0..4) and receive counter rcv (0..4), both reset on entry. mem_req=1, mem_we=0, mem_addr = base + 4*iss while iss<4; iss increments on mem_ready. Each mem_rvalid writes mem_rdata into word rcv of fill buffer, rcv increments. rcv reaching 4 -> DONE.
- DONE: fill_valid=1 for exactly one cycle with fill_addr=base, then IDLE.
- mem_rvalid outside RD, or with rcv=4, is ignored.
- Counters 3 bits; no wrap, saturate at 4.
- Requests presented outside IDLE see ready=0 and are not lost (requester holds).

## Timing
- Reset (rst_n low, asynchronous): state IDLE, all outputs 0 including miss_ready/wr_ready (forced 0 while rst_n low), fill_data 0, counters 0.
- Reset mid-operation abandons the transaction; no fill_valid/wr_done produced. Memory shares rst_n so no stale responses.
- All outputs registered except miss_ready/wr_ready (decoded from state and wr_req).
- Store, mem_ready=1: accept T, mem_req T+1, wr_done T+2, wr_ready again T+2.
- Refill, mem_ready=1, response 1 cycle after accept: accept T, reads issued T+1..T+4, responses T+2..T+5, fill_valid T+6, miss_ready T+7. Minimum refill latency 6 cycles.
- mem_ready low stalls issue with address held; back-to-back issue otherwise.

## Structure
- Package dcache_pkg: state enum, BLOCK_WORDS, BLOCK_OFFSET=2, BYTE_OFFSET=2, TAG/SET widths shared with the cache.
- Single module; no sub-module. Fill buffer is BLOCK_WORDS registers indexed by rcv.

## Test plan
- Reset then miss_addr=0x0000_1234, memory returns addr-as-data, 1-cycle latency -> reads 0x1230,0x1234,0x1238,0x123C; fill_valid at T+6, fill_addr=0x1230, fill_data={0x123C,0x1238,0x1234,0x1230}.
- Store wr_addr=0x40, wr_data=0xDEADBEEF, wr_byte=1 -> one mem_req with mem_we=1, mem_st_byte=1, wr_done at T+2.
- Simultaneous wr_req and miss_req in IDLE -> store completes first (miss_ready=0), refill then accepted; memory sees write before all reads.
- mem_ready low for 3 cycles on 2nd read, random 1-4 cycle response latency -> same fill_data, word order preserved, exactly one fill_valid.
- rst_n low after 2 responses -> outputs 0 immediately; after release, new miss to 0x2000 returns correct block with no stale words.
- Spurious mem_rvalid in IDLE -> no state change, no fill_valid.

Source files
------------

// File: rtl/dcache_pkg.sv
// Constants shared by the data cache and its refill/write-through controller.
package dcache_pkg;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int BLOCK_WORDS  = 4;
    localparam int BLOCK_OFFSET = 2;
    localparam int BYTE_OFFSET  = 2;
    localparam int SET_BITS     = 3;
    localparam int WAYS         = 2;
    localparam int TAG_BITS     = ADDR_W - SET_BITS - BLOCK_OFFSET - BYTE_OFFSET;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/dcache_refill.sv
// Block refill and write-through store controller between the data cache
// and data memory; one memory activity at a time.
module dcache_refill #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              miss_req,
    input  logic [ADDR_WIDTH-1:0]             miss_addr,
    output logic                              miss_ready,
    input  logic                              wr_req,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              wr_byte,
    output logic                              wr_ready,
    output logic                              wr_done,
    output logic                              fill_valid,
    output logic [ADDR_WIDTH-1:0]             fill_addr,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] fill_data,
    output logic                              busy,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic                              mem_st_byte,
    input  logic                              mem_ready,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_rvalid
);
    import dcache_pkg::*;

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK =
        ADDR_WIDTH'(BLOCK_WORDS * (DATA_WIDTH / 8) - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      iss_q, iss_d;
    logic [CNT_W-1:0]      rcv_q, rcv_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] fbuf_q [BLOCK_WORDS];
    logic [DATA_WIDTH-1:0] fbuf_d [BLOCK_WORDS];
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_st_byte_q, mem_st_byte_d;
    logic                  wr_done_q, wr_done_d;
    logic                  fill_valid_q, fill_valid_d;
    logic                  busy_q, busy_d;
    logic                  idle;
    logic                  issue;
    logic                  recv;

    assign idle  = (state_q == ST_IDLE);
    assign issue = mem_req_q & mem_ready;
    assign recv  = (state_q == ST_RD) & mem_rvalid & (rcv_q != CNT_FULL);

    // Stores win a tie so a following refill reads the updated memory.
    assign wr_ready   = rst_n & idle;
    assign miss_ready = rst_n & idle & ~wr_req;

    always_comb begin
        state_d       = state_q;
        iss_d         = iss_q;
        rcv_d         = rcv_q;
        base_d        = base_q;
        fbuf_d        = fbuf_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_st_byte_d = mem_st_byte_q;
        wr_done_d     = 1'b0;
        fill_valid_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    state_d       = ST_WR;
                    mem_req_d     = 1'b1;
                    mem_we_d      = 1'b1;
                    mem_addr_d    = wr_addr;
                    mem_wdata_d   = wr_data;
                    mem_st_byte_d = wr_byte;
                end else if (miss_req) begin
                    state_d       = ST_RD;
                    base_d        = miss_addr & ~OFS_MASK;
                    iss_d         = '0;
                    rcv_d         = '0;
                    mem_req_d     = 1'b1;
                    mem_we_d      = 1'b0;
                    mem_st_byte_d = 1'b0;
                    mem_addr_d    = base_d;
                end
            end
            ST_WR: begin
                if (mem_ready) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    wr_done_d = 1'b1;
                end
            end
            ST_RD: begin
                if (issue) begin
                    iss_d = iss_q + 1'b1;
                end
                mem_req_d = (iss_d != CNT_FULL);
                if (mem_req_d) begin
                    mem_addr_d = base_q + (ADDR_WIDTH'(iss_d) << BYTE_OFFSET);
                end
                if (recv) begin
                    fbuf_d[rcv_q[IDX_W-1:0]] = mem_rdata;
                    rcv_d = rcv_q + 1'b1;
                end
                if (rcv_d == CNT_FULL) begin
                    state_d      = ST_DONE;
                    fill_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            iss_q         <= '0;
            rcv_q         <= '0;
            base_q        <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                fbuf_q[i] <= '0;
            end
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_st_byte_q <= 1'b0;
            wr_done_q     <= 1'b0;
            fill_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            iss_q         <= iss_d;
            rcv_q         <= rcv_d;
            base_q        <= base_d;
            fbuf_q        <= fbuf_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_st_byte_q <= mem_st_byte_d;
            wr_done_q     <= wr_done_d;
            fill_valid_q  <= fill_valid_d;
            busy_q        <= busy_d;
        end
    end

    for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_fill
        assign fill_data[i*DATA_WIDTH +: DATA_WIDTH] = fbuf_q[i];
    end

    assign fill_addr   = base_q;
    assign fill_valid  = fill_valid_q;
    assign wr_done     = wr_done_q;
    assign busy        = busy_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_st_byte = mem_st_byte_q;

endmodule

// File: tb/tb_dcache_refill.sv
// Scoreboard bench for dcache_refill: random traffic against a word-array
// memory reference, plus directed timing, stall, reset and spurious cases.
module tb_dcache_refill;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         miss_ready;
    logic         wr_req = 1'b0;
    logic [31:0]  wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic         wr_byte = 1'b0;
    logic         wr_ready;
    logic         wr_done;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [127:0] fill_data;
    logic         busy;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_st_byte;
    logic         mem_ready = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         mem_rvalid = 1'b0;

    dcache_refill dut (
        .clk(clk), .rst_n(rst_n),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_byte(wr_byte), .wr_ready(wr_ready), .wr_done(wr_done),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_st_byte(mem_st_byte),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] base; logic [127:0] data; int cyc; } fill_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic sb; } st_t;
    typedef struct { logic [31:0] data; int due; } rsp_t;

    int total = 0;
    int bad = 0;
    int ncyc = 0;
    int mcyc = 0;
    int fill_cnt = 0;
    int resp_cnt = 0;
    int rd_cnt = 0;
    int last_due = 0;
    int st_acc = 0;
    int ms_acc = 0;
    int lat_min = 1;
    int lat_max = 1;
    int rdy_pct = 100;
    int stall_left = 0;
    bit spur = 0;
    bit held = 0;
    logic [31:0] held_addr = '0;

    fill_t exp_fill[$];
    st_t   exp_wr[$];
    int    exp_done[$];
    rsp_t  pend[$];

    // Reference view of memory (updated when a store is accepted) and the
    // memory model's own contents (updated when the write reaches memory).
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] phys[logic [31:0]];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [31:0] wkey(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(wkey(a)) ? ref_mem[wkey(a)] : wkey(a);
    endfunction

    function automatic logic [31:0] phys_get(input logic [31:0] a);
        return phys.exists(wkey(a)) ? phys[wkey(a)] : wkey(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
            input logic [31:0] a, input logic [31:0] d, input logic sb);
        logic [31:0] w;
        w = old;
        if (sb) w[8*a[1:0] +: 8] = d[7:0];
        else w = d;
        return w;
    endfunction

    function automatic logic [255:0] outs();
        return {mem_req, mem_we, mem_addr, mem_wdata, mem_st_byte,
                fill_valid, fill_addr, fill_data, busy, wr_done,
                miss_ready, wr_ready};
    endfunction

    // Memory model: random ready, in-order responses with random latency.
    always @(negedge clk) begin
        rsp_t r;
        int lat;
        int due;
        mcyc++;
        if (!rst_n) begin
            pend.delete();
            rd_cnt = 0;
            last_due = 0;
            held = 0;
            mem_ready = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = '0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (pend.size() != 0 && pend[0].due <= mcyc) begin
                r = pend.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata = r.data;
                resp_cnt++;
            end else if (spur) begin
                mem_rvalid = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
                spur = 0;
            end
            mem_ready = ($urandom_range(99) < rdy_pct);
            if (mem_req && !mem_we && rd_cnt % 4 == 1 && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end
            if (held) begin
                chk("held_req", mem_req, 1);
                chk("held_addr", mem_addr, held_addr);
            end
            held = mem_req && !mem_ready;
            held_addr = mem_addr;
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    chk("wr_inside_refill", rd_cnt % 4, 0);
                    if (exp_wr.size() == 0) begin
                        flag("unexpected_mem_write");
                    end else begin
                        st_t e;
                        e = exp_wr.pop_front();
                        chk("mem_write", {mem_addr, mem_wdata, mem_st_byte},
                            {e.addr, e.data, e.sb});
                    end
                    phys[wkey(mem_addr)] = merge(phys_get(mem_addr), mem_addr,
                                                 mem_wdata, mem_st_byte);
                end else begin
                    if (exp_fill.size() == 0) flag("unexpected_mem_read");
                    else chk("rd_addr", mem_addr,
                             exp_fill[0].base + 32'(4 * (rd_cnt % 4)));
                    rd_cnt++;
                    lat = $urandom_range(lat_max, lat_min);
                    due = mcyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    r.data = phys_get(mem_addr);
                    r.due = due;
                    pend.push_back(r);
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        fill_t f;
        int dc;
        ncyc++;
        if (rst_n) begin
            if (fill_valid) begin
                fill_cnt++;
                if (exp_fill.size() == 0) begin
                    flag("fill_unexpected");
                end else begin
                    f = exp_fill.pop_front();
                    chk("fill_addr", fill_addr, f.base);
                    chk("fill_data", fill_data, f.data);
                    if (f.cyc >= 0) chk("fill_time", ncyc, f.cyc);
                end
            end
            if (wr_done) begin
                if (exp_done.size() == 0) begin
                    flag("wr_done_unexpected");
                end else begin
                    dc = exp_done.pop_front();
                    if (dc >= 0) chk("wr_done_time", ncyc, dc);
                end
            end
        end
    end

    task automatic do_miss(input logic [31:0] a, input bit timed);
        int n;
        fill_t f;
        n = 0;
        @(negedge clk);
        miss_addr = a;
        miss_req = 1'b1;
        #1;
        while (!miss_ready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 500) begin
                flag("miss_accept_timeout");
                miss_req = 1'b0;
                return;
            end
        end
        ms_acc = ncyc;
        f.base = a & ~32'hF;
        for (int i = 0; i < 4; i++) f.data[32*i +: 32] = ref_get(f.base + 32'(4 * i));
        f.cyc = timed ? ncyc + 6 : -1;
        exp_fill.push_back(f);
        @(posedge clk);
        #1;
        miss_req = 1'b0;
        miss_addr = $urandom;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic sb, input bit timed);
        int n;
        st_t e;
        n = 0;
        @(negedge clk);
        wr_addr = a;
        wr_data = d;
        wr_byte = sb;
        wr_req = 1'b1;
        #1;
        while (!wr_ready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 500) begin
                flag("store_accept_timeout");
                wr_req = 1'b0;
                return;
            end
        end
        st_acc = ncyc;
        e.addr = a;
        e.data = d;
        e.sb = sb;
        exp_wr.push_back(e);
        exp_done.push_back(timed ? ncyc + 2 : -1);
        ref_mem[wkey(a)] = merge(ref_get(a), a, d, sb);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (ncyc < c) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (busy || exp_fill.size() != 0 || exp_done.size() != 0 ||
               exp_wr.size() != 0) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 1000) begin
                flag("idle_timeout");
                exp_fill.delete();
                exp_done.delete();
                exp_wr.delete();
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int r;
        int n;
        int k;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", outs(), '0);
        rst_n = 1'b1;

        do_miss(32'h0000_1234, 1);
        acc = ms_acc;
        wait_cyc(acc + 6);
        chk("done_state", {busy, miss_ready}, 2'b10);
        wait_cyc(acc + 7);
        chk("miss_ready_again", miss_ready, 1);
        wait_idle();

        do_store(32'h40, 32'hDEAD_BEEF, 1'b1, 1);
        acc = st_acc;
        wait_cyc(acc + 1);
        chk("store_issue", {mem_req, mem_we, mem_st_byte, wr_ready}, 4'b1110);
        wait_cyc(acc + 2);
        chk("wr_ready_again", wr_ready, 1);
        wait_idle();

        fork
            do_store(32'h1004, 32'hCAFE_F00D, 1'b0, 0);
            do_miss(32'h1008, 0);
            begin
                @(negedge clk);
                #2;
                chk("miss_blocked_by_store", {wr_ready, miss_ready}, 2'b10);
            end
        join
        chk("store_before_miss", st_acc < ms_acc, 1);
        wait_idle();

        lat_min = 1;
        lat_max = 4;
        stall_left = 3;
        r = fill_cnt;
        do_miss(32'h0000_1234, 0);
        wait_idle();
        chk("stall_single_fill", fill_cnt - r, 1);
        chk("stall_applied", stall_left, 0);

        r = resp_cnt;
        do_miss(32'h0000_3000, 0);
        n = 0;
        while (resp_cnt < r + 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) flag("resp_wait_timeout");
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", outs(), '0);
        exp_fill.delete();
        exp_done.delete();
        exp_wr.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        do_miss(32'h0000_2000, 0);
        wait_idle();

        r = fill_cnt;
        @(negedge clk);
        spur = 1;
        repeat (4) @(negedge clk);
        #1;
        chk("spurious_busy", busy, 0);
        chk("spurious_no_fill", fill_cnt, r);
        do_miss(32'h0000_1238, 0);
        wait_idle();

        rdy_pct = 70;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(3);
            a = 32'h1000 + 32'($urandom_range(255));
            case (k)
                0: do_miss(a, 0);
                1: do_store(a & ~32'h3, $urandom, 1'b0, 0);
                2: do_store(a, $urandom, 1'b1, 0);
                default: begin
                    fork
                        do_store(a, $urandom, 1'($urandom_range(1)), 0);
                        do_miss(a ^ 32'h8, 0);
                    join
                end
            endcase
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
